// File: rtl/out_decimal_tx_if.sv
// -----------------------------------------------------------------------------
// out_decimal_tx_if
// Purpose : groups the CPU capture bus and the ASCII character handshake of
//           out_decimal_tx into one bundle.
// Signals : doOut      - CPU output strobe (capture dbus at a rising edge)
//           dbus[7:0]  - CPU data byte
//           char[7:0]  - ASCII character offered by the formatter
//           char_valid - char is valid, held until accepted
//           char_ready - sink accepts char when char_valid is also high
// Modports: master - CPU/sink side (drives doOut, dbus, char_ready)
//           slave  - formatter side (drives char, char_valid)
// -----------------------------------------------------------------------------
interface out_decimal_tx_if;
  logic       doOut;
  logic [7:0] dbus;
  logic [7:0] char;
  logic       char_valid;
  logic       char_ready;

  modport master (
    output doOut,
    output dbus,
    output char_ready,
    input  char,
    input  char_valid
  );

  modport slave (
    input  doOut,
    input  dbus,
    input  char_ready,
    output char,
    output char_valid
  );
endinterface

// File: rtl/out_decimal_tx.sv
// -----------------------------------------------------------------------------
// out_decimal_tx
// Purpose : captures CPU output bytes into a small FIFO and streams each byte
//           as three zero-padded decimal ASCII digits followed by a line feed.
//           Digits are found by repeated subtraction (100s, then 10s), one
//           subtraction per clock.
// Ports   : clk        - system clock, rising edge
//           reset      - asynchronous, active-high; clears all control state
//           bus        - out_decimal_tx_if.slave (doOut/dbus capture,
//                        char/char_valid/char_ready stream)
//           overflow   - sticky: a captured byte was dropped (FIFO full)
//           busy       - FIFO non-empty or formatter not idle
//           fifo_count - bytes currently queued (0..DEPTH)
// Params  : DEPTH      - FIFO depth, power of two in 2..8
// -----------------------------------------------------------------------------
module out_decimal_tx #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  out_decimal_tx_if.slave  bus,
  output logic             overflow,
  output logic             busy,
  output logic [3:0]       fifo_count
);

  localparam int         PW      = $clog2(DEPTH);
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HSUB,
    S_TSUB,
    S_EMIT_H,
    S_EMIT_T,
    S_EMIT_O,
    S_EMIT_NL
  } state_t;

  // FIFO storage and control
  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [3:0]    r_count;
  logic          r_overflow;

  // Formatter state and datapath
  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_work;
  logic [7:0]    w_work_nxt;
  logic [3:0]    r_hund;
  logic [3:0]    w_hund_nxt;
  logic [3:0]    r_tens;
  logic [3:0]    w_tens_nxt;

  logic          w_pop;
  logic          w_push;
  logic [7:0]    w_head;
  logic [7:0]    w_char;
  logic          w_char_valid;

  assign w_head = r_mem[r_rd_ptr];

  // A full FIFO still accepts a byte when the formatter pops at the same edge.
  assign w_push = bus.doOut && ((r_count < DEPTH_C) || w_pop);

  // ---------------------------------------------------------------------------
  // Formatter next-state, datapath and character outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_work_nxt   = r_work;
    w_hund_nxt   = r_hund;
    w_tens_nxt   = r_tens;
    w_pop        = 1'b0;
    w_char       = 8'h00;
    w_char_valid = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (r_count != 4'd0) begin
          w_pop       = 1'b1;
          w_work_nxt  = w_head;
          w_hund_nxt  = 4'd0;
          w_tens_nxt  = 4'd0;
          w_state_nxt = S_HSUB;
        end
      end
      S_HSUB: begin
        if (r_work >= 8'd100) begin
          w_work_nxt = r_work - 8'd100;
          w_hund_nxt = r_hund + 4'd1;
        end else begin
          w_state_nxt = S_TSUB;
        end
      end
      S_TSUB: begin
        // Leaving TSUB, work already holds the ones digit.
        if (r_work >= 8'd10) begin
          w_work_nxt = r_work - 8'd10;
          w_tens_nxt = r_tens + 4'd1;
        end else begin
          w_state_nxt = S_EMIT_H;
        end
      end
      S_EMIT_H: begin
        w_char       = 8'h30 + {4'd0, r_hund};
        w_char_valid = 1'b1;
        if (bus.char_ready) w_state_nxt = S_EMIT_T;
      end
      S_EMIT_T: begin
        w_char       = 8'h30 + {4'd0, r_tens};
        w_char_valid = 1'b1;
        if (bus.char_ready) w_state_nxt = S_EMIT_O;
      end
      S_EMIT_O: begin
        w_char       = 8'h30 + r_work;
        w_char_valid = 1'b1;
        if (bus.char_ready) w_state_nxt = S_EMIT_NL;
      end
      S_EMIT_NL: begin
        w_char       = 8'h0A;
        w_char_valid = 1'b1;
        if (bus.char_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Formatter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_work  <= 8'd0;
      r_hund  <= 4'd0;
      r_tens  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      r_hund  <= w_hund_nxt;
      r_tens  <= w_tens_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= 4'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
      if (bus.doOut && !w_push) r_overflow <= 1'b1;
    end
  end

  // FIFO storage carries data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.dbus;
  end

  assign bus.char       = w_char;
  assign bus.char_valid = w_char_valid;
  assign overflow       = r_overflow;
  assign busy           = (r_count != 4'd0) || (r_state != S_IDLE);
  assign fifo_count     = r_count;

endmodule

// File: tb/tb_out_decimal_tx.sv
// -----------------------------------------------------------------------------
// tb_out_decimal_tx
// Directed bench for out_decimal_tx (DEPTH=4). Expected character streams,
// latencies and flag values are written out by hand for each vector.
// -----------------------------------------------------------------------------
module tb_out_decimal_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       overflow;
  logic       busy;
  logic [3:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  out_decimal_tx_if bus ();

  out_decimal_tx #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .overflow   (overflow),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    bus.doOut = 1'b1;
    bus.dbus  = v;
    tick();
    bus.doOut = 1'b0;
  endtask

  // Wait (bounded) for char_valid, then require four characters on four
  // consecutive accepting edges. exp_lat < 0 skips the latency check.
  task automatic expect_rec(input string tag, input string exp, input int exp_lat);
    int n;
    n = 0;
    while (bus.char_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_start"}, 32'(bus.char_valid), 32'd1);
    if (exp_lat >= 0) chk({tag, "_lat"}, n, exp_lat);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_c%0d", tag, i), {23'd0, bus.char_valid, bus.char},
          {23'd0, 1'b1, exp[i]});
      tick();
    end
  endtask

  initial begin
    int   n;
    logic seen;

    reset          = 1'b1;
    bus.doOut      = 1'b0;
    bus.dbus       = 8'h00;
    bus.char_ready = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_valid", 32'(bus.char_valid), 32'd0);
    chk("rst_char",  32'(bus.char),       32'd0);
    chk("rst_count", 32'(fifo_count),     32'd0);
    chk("rst_ovf",   32'(overflow),       32'd0);
    chk("rst_busy",  32'(busy),           32'd0);
    #2 reset = 1'b0;
    tick();

    // Value 7: first valid three edges after the push, then "007\n"
    bus.char_ready = 1'b1;
    push(8'd7);
    chk("v7_count", 32'(fifo_count), 32'd1);
    expect_rec("v7", "007\n", 3);
    chk("v7_busy", 32'(busy), 32'd0);

    // Value 255: ten edges of latency
    push(8'd255);
    expect_rec("v255", "255\n", 10);
    chk("v255_busy", 32'(busy), 32'd0);

    // Value 42 under backpressure
    bus.char_ready = 1'b0;
    push(8'd42);
    n = 0;
    while (bus.char_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d", i), {23'd0, bus.char_valid, bus.char}, {23'd0, 9'h130});
      tick();
    end
    bus.char_ready = 1'b1;
    expect_rec("v42", "042\n", 0);

    // Fill and overflow: six pushes, fifth leaves FIFO full, sixth dropped
    bus.char_ready = 1'b0;
    for (int v = 1; v <= 6; v++) begin
      bus.doOut = 1'b1;
      bus.dbus  = 8'(v);
      tick();
      if (v == 5) chk("fill_count_e4", 32'(fifo_count), 32'd4);
    end
    bus.doOut = 1'b0;
    chk("fill_count_e5", 32'(fifo_count), 32'd4);
    chk("fill_ovf",      32'(overflow),   32'd1);
    bus.char_ready = 1'b1;
    expect_rec("f1", "001\n", -1);
    expect_rec("f2", "002\n", -1);
    expect_rec("f3", "003\n", -1);
    expect_rec("f4", "004\n", -1);
    expect_rec("f5", "005\n", -1);
    chk("fill_end_count", 32'(fifo_count), 32'd0);
    chk("fill_end_busy",  32'(busy),       32'd0);
    chk("fill_end_ovf",   32'(overflow),   32'd1);

    // Back-to-back 0, 100, 10
    push(8'd0);
    push(8'd100);
    push(8'd10);
    expect_rec("b0",   "000\n", -1);
    expect_rec("b100", "100\n", -1);
    expect_rec("b10",  "010\n", -1);

    // Reset during EMIT_T of 123 with another byte queued
    bus.char_ready = 1'b0;
    push(8'd123);
    push(8'd9);
    n = 0;
    while (bus.char_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("r123_h", {23'd0, bus.char_valid, bus.char}, {23'd0, 9'h131});
    bus.char_ready = 1'b1;
    tick();
    bus.char_ready = 1'b0;
    chk("r123_t", {23'd0, bus.char_valid, bus.char}, {23'd0, 9'h132});
    chk("r123_q", 32'(fifo_count), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.char_valid), 32'd0);
    chk("arst_char",  32'(bus.char),       32'd0);
    chk("arst_count", 32'(fifo_count),     32'd0);
    chk("arst_ovf",   32'(overflow),       32'd0);
    chk("arst_busy",  32'(busy),           32'd0);
    #2 reset = 1'b0;
    bus.char_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.char_valid !== 1'b0) seen = 1'b1;
    end
    chk("post_rst_quiet", 32'(seen), 32'd0);

    // First edge after a reset release captures normally
    reset = 1'b1;
    #2 reset = 1'b0;
    push(8'd5);
    chk("post_rst_cap", 32'(fifo_count), 32'd1);
    expect_rec("v5", "005\n", 3);
    chk("v5_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
